// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Wallace-tree multiplier with a Kogge-Stone final adder,
// valid/ready flow control and a sideband tag. Define WALLACE_SIGNED_EN for Baugh-Wooley signed mode.
module wallace_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NCOL = 2 * WIDTH;
  localparam int MAXH = WIDTH + 2;  // tallest column plus room for the Baugh-Wooley constants
  localparam int NLVL = 2 * WIDTH;  // loose bound on reduction depth; idle levels do nothing

  // Pipeline occupancy and advance chain: a stage moves when its successor is empty or moving.
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  assign adv3     = out_ready;
  assign adv2     = !v3 || adv3;
  assign adv1     = !v2 || adv2;
  assign in_ready = !v1 || adv1;

  // ---------------------------------------------------------------- S1: operand capture
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [TAG_W-1:0] s1_tag;
`ifdef WALLACE_SIGNED_EN
  logic             s1_sgn;
`else
  logic             unused_signed;
  assign unused_signed = in_signed;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every stage reads pre-edge values.
    // NOTE: data registers are cleared along with the valid bits so the outputs never carry X.
    if (rst) begin
      v1     <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
`ifdef WALLACE_SIGNED_EN
      s1_sgn <= 1'b0;
`endif
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
`ifdef WALLACE_SIGNED_EN
        s1_sgn <= in_signed;
`endif
      end
    end
  end

  // ---------------------------------------------------------------- S2: partial products + Wallace tree
  logic [NCOL-1:0] red_sum, red_carry;

  always_comb begin : wallace_tree
    logic [MAXH-1:0] col [NCOL];
    logic [MAXH-1:0] nxt [NCOL];
    int              ht  [NCOL];
    int              nht [NCOL];
    int              base;
    logic            pp, busy, x0, x1, x2;

    // NOTE: every local and output gets a default before any conditional write, so no latch is inferred.
    for (int c = 0; c < NCOL; c++) begin
      col[c] = '0;
      nxt[c] = '0;
      ht[c]  = 0;
      nht[c] = 0;
    end
    base      = 0;
    pp        = 1'b0;
    busy      = 1'b0;
    x0        = 1'b0;
    x1        = 1'b0;
    x2        = 1'b0;
    red_sum   = '0;
    red_carry = '0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = s1_a[j] & s1_b[i];
`ifdef WALLACE_SIGNED_EN
        // Baugh-Wooley: invert the row MSBs and the final row, the corner bit stays true.
        if (s1_sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp = ~pp;
`endif
        col[i+j][ht[i+j]] = pp;
        ht[i+j]           = ht[i+j] + 1;
      end
    end
`ifdef WALLACE_SIGNED_EN
    col[WIDTH][ht[WIDTH]]   = s1_sgn;
    ht[WIDTH]               = ht[WIDTH] + 1;
    col[NCOL-1][ht[NCOL-1]] = s1_sgn;
    ht[NCOL-1]              = ht[NCOL-1] + 1;
`endif

    // Each level compresses every column in parallel: triples through full adders,
    // a leftover pair through a half adder, a leftover single bit passes through.
    for (int l = 0; l < NLVL; l++) begin
      busy = 1'b0;
      for (int c = 0; c < NCOL; c++) begin
        if (ht[c] > 2) busy = 1'b1;
      end
      if (busy) begin
        for (int c = 0; c < NCOL; c++) begin
          nxt[c] = '0;
          nht[c] = 0;
        end
        for (int c = 0; c < NCOL; c++) begin
          base = (ht[c] / 3) * 3;
          for (int k = 0; k + 2 < MAXH; k += 3) begin
            if (k + 2 < ht[c]) begin
              x0 = col[c][k];
              x1 = col[c][k+1];
              x2 = col[c][k+2];
              nxt[c][nht[c]] = x0 ^ x1 ^ x2;
              nht[c]         = nht[c] + 1;
              if (c + 1 < NCOL) begin
                nxt[c+1][nht[c+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
                nht[c+1]           = nht[c+1] + 1;
              end
            end
          end
          if (ht[c] - base == 2) begin
            x0 = col[c][base];
            x1 = col[c][base+1];
            nxt[c][nht[c]] = x0 ^ x1;
            nht[c]         = nht[c] + 1;
            if (c + 1 < NCOL) begin
              nxt[c+1][nht[c+1]] = x0 & x1;
              nht[c+1]           = nht[c+1] + 1;
            end
          end else if (ht[c] - base == 1) begin
            nxt[c][nht[c]] = col[c][base];
            nht[c]         = nht[c] + 1;
          end
        end
        col = nxt;
        ht  = nht;
      end
    end

    for (int c = 0; c < NCOL; c++) begin
      if (ht[c] > 0) red_sum[c]   = col[c][0];
      if (ht[c] > 1) red_carry[c] = col[c][1];
    end
  end

  logic [NCOL-1:0]  s2_sum, s2_carry;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2       <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= '0;
      s2_tag   <= '0;
    end else if (adv1) begin
      v2 <= v1;
      if (v1) begin
        s2_sum   <= red_sum;
        s2_carry <= red_carry;
        s2_tag   <= s1_tag;
      end
    end
  end

  // ---------------------------------------------------------------- S3: Kogge-Stone carry-propagate adder
  logic [NCOL-1:0] ks_sum;

  always_comb begin : kogge_stone
    logic [NCOL-1:0] g, p, g_n, p_n;
    g   = s2_sum & s2_carry;
    p   = s2_sum ^ s2_carry;
    g_n = g;
    p_n = p;
    for (int d = 1; d < NCOL; d = d * 2) begin
      g_n = g;
      p_n = p;
      for (int i = d; i < NCOL; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-d]);
        p_n[i] = p[i] & p[i-d];
      end
      g = g_n;
      p = p_n;
    end
    // Carry into bit i is the group generate of bits i-1..0; carry out of the top bit is dropped.
    ks_sum = (s2_sum ^ s2_carry) ^ {g[NCOL-2:0], 1'b0};
  end

  logic [NCOL-1:0]  s3_prod;
  logic [TAG_W-1:0] s3_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3      <= 1'b0;
      s3_prod <= '0;
      s3_tag  <= '0;
    end else if (adv2) begin
      v3 <= v2;
      if (v2) begin
        s3_prod <= ks_sum;
        s3_tag  <= s2_tag;
      end
    end
  end

  assign out_valid = v3;
  assign out_prod  = s3_prod;
  assign out_tag   = s3_tag;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Scoreboard bench for wallace_mult_pipe: the driver pushes model results on accept,
// a negedge monitor pops and compares on every output transfer.
module tb_wallace_mult_pipe;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int PW    = 2 * WIDTH;
`ifdef WALLACE_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct packed {
    logic [PW-1:0]    prod;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_signed = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PW-1:0]    out_prod;
  logic [TAG_W-1:0] out_tag;

  wallace_mult_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   stalls   = 0;
  int   cycle    = 0;
  exp_t sb[$];
  int   pop_log[$];
  exp_t mon_e;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer multiply, sign-extended operands in signed mode, truncated to 2*WIDTH.
  function automatic logic [PW-1:0] ref_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic s);
    longint sa, sb_v, p;
    if (s && SIGNED_EN) begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
    end else begin
      sa   = longint'(a);
      sb_v = longint'(b);
    end
    p = sa * sb_v;
    return p[PW-1:0];
  endfunction

  // Output monitor: compares every output transfer against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got prod 0x%0h tag %0d, expected no output", out_prod, out_tag);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("prod_tag%0d", mon_e.tag), 64'(out_prod), 64'(mon_e.prod));
        check("tag_order", 64'(out_tag), 64'(mon_e.tag));
      end
      pop_log.push_back(cycle);
    end
  end

  // Present one operation, wait (bounded) for acceptance, record the expected result.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                       input logic [TAG_W-1:0] tag, input logic [PW-1:0] exp);
    int waits;
    waits     = 0;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = tag;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: tag %0d not accepted, expected acceptance within 50 cycles", tag);
    end else begin
      sb.push_back('{prod: exp, tag: tag});
    end
    stalls += waits;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] ra, rb;
  logic             rs;
  logic [PW-1:0]    held_p;
  logic [TAG_W-1:0] held_t;
  int               lat;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_prod", 64'(out_prod), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Unsigned corners, with latency measured on the first
    issue(8'hFF, 8'hFF, 1'b0, 4'd1, 16'hFE01);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency_cycles", 64'(lat), 64'd3);
    @(posedge clk);
    #1;
    issue(8'h00, 8'hA5, 1'b0, 4'd2, 16'h0000);
    issue(8'h0D, 8'h0B, 1'b0, 4'd3, 16'h008F);
    drain();

    // Signed products interleaved with unsigned, back to back
    issue(8'hFF, 8'hFF, 1'b1, 4'd4, SIGNED_EN ? 16'h0001 : 16'hFE01);
    issue(8'h80, 8'h7F, 1'b1, 4'd5, SIGNED_EN ? 16'hC080 : 16'h3F80);
    issue(8'hFF, 8'hFF, 1'b0, 4'd6, 16'hFE01);
    issue(8'h80, 8'h80, 1'b1, 4'd7, 16'h4000);
    drain();

    // Streaming: 100 random back-to-back operations
    pop_log.delete();
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      rs = 1'($urandom());
      issue(ra, rb, rs, TAG_W'(i % 16), ref_mult(ra, rb, rs));
    end
    drain();
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_results", 64'(pop_log.size()), 64'd100);
    if (pop_log.size() == 100)
      check("stream_span_cycles", 64'(pop_log[99] - pop_log[0]), 64'd99);

    // Backpressure: three in flight fill the pipe, the fourth waits for the first pop
    out_ready = 1'b0;
    issue(8'h11, 8'h22, 1'b0, 4'd1, ref_mult(8'h11, 8'h22, 1'b0));
    issue(8'h9C, 8'h37, 1'b0, 4'd2, ref_mult(8'h9C, 8'h37, 1'b0));
    issue(8'hF0, 8'h81, 1'b1, 4'd3, ref_mult(8'hF0, 8'h81, 1'b1));
    in_valid  = 1'b1;
    in_a      = 8'h5A;
    in_b      = 8'hC3;
    in_signed = 1'b0;
    in_tag    = 4'd4;
    @(negedge clk);
    check("bp_in_ready_full", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_head_tag", 64'(out_tag), 64'd1);
    held_p = out_prod;
    held_t = out_tag;
    repeat (2) @(negedge clk);
    check("bp_hold_prod", 64'(out_prod), 64'(held_p));
    check("bp_hold_tag", 64'(out_tag), 64'(held_t));
    check("bp_still_blocked", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_with_pop", 64'({in_ready, out_valid}), 64'd3);
    if (in_ready) sb.push_back('{prod: ref_mult(8'h5A, 8'hC3, 1'b0), tag: 4'd4});
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Reset with two operations in flight
    issue(8'h77, 8'h66, 1'b0, 4'd9, ref_mult(8'h77, 8'h66, 1'b0));
    issue(8'hEE, 8'hDD, 1'b0, 4'd10, ref_mult(8'hEE, 8'hDD, 1'b0));
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_prod", 64'(out_prod), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    issue(8'h03, 8'h05, 1'b0, 4'd11, 16'h000F);
    drain();
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined WIDTH x WIDTH Wallace-tree multiplier with a Kogge-Stone final carry-propagate adder.
- Successor to the team's fixed 4x4 combinational Wallace multiplier.
- Adds clocking, valid/ready flow control with backpressure, a per-transaction tag, and optional signed (Baugh-Wooley) operation.
- Sits between the operand-issue logic and the result writeback in the arithmetic datapath.

Parameters:
WIDTH, 8, operand width in bits (>=4); product is 2*WIDTH bits
TAG_W, 4, width of the sideband tag carried alongside each operation

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair and tag valid
in_ready  output  1  block can accept an operation this cycle
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
in_signed  input  1  1 = two's-complement operands (honoured only with WALLACE_SIGNED_EN)
in_tag  input  TAG_W  sideband tag, returned unchanged with the product
out_valid  output  1  product and tag valid
out_ready  input  1  consumer accepts the result this cycle
out_prod  output  2*WIDTH  product a*b
out_tag  output  TAG_W  tag of this product

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Pipeline stages:
  - S1: registers a, b, signed, tag.
  - S2: partial-product generation plus full Wallace reduction (3:2 full adders, 2:2 half adders) down to two rows, registered as sum and carry vectors of 2*WIDTH bits.
  - S3: Kogge-Stone prefix addition of the sum and carry rows, result registered.
- Each stage has a valid bit. Fixed latency is 3 cycles from an accepted input to out_valid when there is no backpressure. Throughput is 1 operation per cycle.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - A stage advances when the next stage is empty or advancing. adv3 = out_ready. adv2 = !v3 || adv3. adv1 = !v2 || adv2. in_ready = !v1 || adv1.
  - Bubbles collapse. in_ready is combinational from out_ready.
  - out_prod and out_tag hold stable while out_valid && !out_ready.
  - Results leave in issue order. Capacity is 3 in-flight operations. With out_ready low and all three stages valid, in_ready = 0.
- Reset:
  - Clears all valid bits, so out_valid = 0 and out_prod = 0 / out_tag = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset asserted mid-operation discards all in-flight operations, with no partial output.
  - Data registers are zeroed on reset, so out_prod never shows X.
- Arithmetic:
  - Unsigned: the full 2*WIDTH-bit product, no truncation, no overflow possible.
  - Final-adder carry-out beyond bit 2*WIDTH-1 is discarded. For valid operand ranges it is always 0 in unsigned mode and is sign-correct in signed mode.
- Simultaneous events: an input accept and an output pop in the same cycle are both performed, and occupancy is unchanged.
- Input hold rule: in_a, in_b, in_signed and in_tag are sampled only on transfer. Values presented while in_ready = 0 are ignored.

Optional Feature:
- Macro: WALLACE_SIGNED_EN.
- Defined:
  - in_signed is captured per transaction.
  - When 1, partial products use the Baugh-Wooley form: row MSBs and the final row are inverted, with constant 1s injected at columns WIDTH and 2*WIDTH-1.
  - out_prod is the two's-complement 2*WIDTH-bit product.
  - Signed and unsigned operations may be interleaved back to back.
- Undefined:
  - in_signed is ignored and treated as 0.
  - The Baugh-Wooley logic is absent, and all products are unsigned.
  - The port list is unchanged.

Test Plan:
- Unsigned corner cases (WIDTH=8, in_signed=0): a=0xFF, b=0xFF -> out_prod=0xFE01 exactly 3 cycles later. a=0x00, b=0xA5 -> 0x0000. a=0x0D, b=0x0B -> 0x008F.
- Signed products (WALLACE_SIGNED_EN, WIDTH=8): (-1)*(-1), i.e. 0xFF*0xFF -> 0x0001. 0x80*0x7F -> 0xC080 (-16256). 0x80*0x80 -> 0x4000. Interleave with the unsigned 0xFF*0xFF, which gives 0xFE01 in order.
- Streaming: 100 random back-to-back ops with out_ready=1 and tags 0..15 cycling -> in_ready never drops, one result per cycle, products match the reference model, tags in order.
- Backpressure: issue tags 1,2,3,4 with out_ready=0 -> in_ready=0 once 3 ops are in flight, so tag 4 is held off. out_prod stays stable. Raise out_ready -> tags 1,2,3,4 emerge in order with correct products, and tag 4 is accepted the same cycle tag 1 pops.
- Reset mid-stream: 2 ops in flight, assert rst for 1 cycle -> next cycle out_valid=0, out_prod=0, in_ready=1. A new op 0x03*0x05 -> 0x000F with no stale results emitted.
- Width scaling: WIDTH=16 gives 0xFFFF*0xFFFF=0xFFFE0001 and 0x1234*0x5678=0x06260060. WIDTH=4 gives 0xF*0xF=0xE1, with 3-cycle latency.
